simd_wb_merge: RTL and testbench

Writeback merge stage that sits directly upstream of the SIMD FP register file's write port. It takes scalar FP results (one register, one lane) and SIMD FP results (one row, up to four lanes) and produces a single registered row write per cycle with a 4-bit lane enable. When a scalar result targets a free lane of the row being written, it is merged into the SIMD write. A small FIFO holds scalar results that cannot issue yet, and per-register write order is preserved.

---
 rtl/simd_wb_merge.sv | 176 +++++++++++++++++
 tb/tb_simd_wb_merge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_wb_merge.sv
// Writeback merge stage ahead of the SIMD FP register file write port.
// Folds scalar results into free lanes of SIMD row writes and buffers the rest in a small FIFO.
module simd_wb_merge #(
    parameter  int width_p       = 33,
    parameter  int els_p         = 32,
    parameter  int buf_els_p     = 2,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          scalar_v_i,
    input  logic [addr_width_lp-1:0]      scalar_addr_i,
    input  logic [width_p-1:0]            scalar_data_i,
    output logic                          scalar_ready_o,
    input  logic                          simd_v_i,
    input  logic [addr_width_lp-1:0]      simd_addr_i,
    input  logic [3:0]                    simd_mask_i,
    input  logic [3:0][width_p-1:0]       simd_data_i,
    output logic                          simd_ready_o,
    output logic [3:0]                    w_v_o,
    output logic [addr_width_lp-1:0]      w_addr_o,
    output logic [3:0][width_p-1:0]       w_data_o
);

    localparam int ptr_w_lp = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
    localparam int cnt_w_lp = $clog2(buf_els_p + 1);

    logic [addr_width_lp-1:0] fifo_addr_q [buf_els_p];
    logic [width_p-1:0]       fifo_data_q [buf_els_p];
    logic [buf_els_p-1:0]     fifo_vld_q;
    logic [ptr_w_lp-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0]      count_q, count_d;

    logic [3:0]               w_v_q, w_v_d;
    logic [addr_width_lp-1:0] w_addr_q, w_addr_d;
    logic [3:0][width_p-1:0]  w_data_q, w_data_d;

    logic                     full_s, empty_s, hazard_s;
    logic                     cand_v_s, cand_issue_s, simd_acc_s, scalar_acc_s;
    logic                     push_s, pop_s;
    logic [addr_width_lp-1:0] cand_addr_s;
    logic [width_p-1:0]       cand_data_s;
    logic                     unused_s;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        if (p == ptr_w_lp'(buf_els_p - 1)) begin
            return {ptr_w_lp{1'b0}};
        end else begin
            return p + ptr_w_lp'(1);
        end
    endfunction

    assign unused_s = ^simd_addr_i[1:0];

    // Readiness, hazard detection, scalar candidate selection and issue decision.
    always_comb begin
        full_s   = (count_q == cnt_w_lp'(buf_els_p));
        empty_s  = (count_q == {cnt_w_lp{1'b0}});
        hazard_s = 1'b0;
        for (int i = 0; i < buf_els_p; i++) begin
            if (fifo_vld_q[i] && (fifo_addr_q[i][addr_width_lp-1:2] == simd_addr_i[addr_width_lp-1:2])
                && simd_mask_i[fifo_addr_q[i][1:0]]) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        if (scalar_v_i && (scalar_addr_i[addr_width_lp-1:2] == simd_addr_i[addr_width_lp-1:2])
            && simd_mask_i[scalar_addr_i[1:0]]) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = hazard_s;
        end

        scalar_ready_o = ~full_s;
        simd_ready_o   = ~full_s & ~hazard_s;
        simd_acc_s     = simd_v_i & simd_ready_o;
        scalar_acc_s   = scalar_v_i & ~full_s;

        // FIFO head is always older than the live input, so it wins candidacy.
        if (!empty_s) begin
            cand_v_s    = 1'b1;
            cand_addr_s = fifo_addr_q[rd_ptr_q];
            cand_data_s = fifo_data_q[rd_ptr_q];
        end else begin
            cand_v_s    = scalar_v_i;
            cand_addr_s = scalar_addr_i;
            cand_data_s = scalar_data_i;
        end

        w_v_d        = 4'b0000;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        cand_issue_s = 1'b0;
        if (simd_acc_s) begin
            w_v_d    = simd_mask_i;
            w_addr_d = {simd_addr_i[addr_width_lp-1:2], 2'b00};
            w_data_d = simd_data_i;
            if (cand_v_s && (cand_addr_s[addr_width_lp-1:2] == simd_addr_i[addr_width_lp-1:2])
                && !simd_mask_i[cand_addr_s[1:0]]) begin
                w_v_d[cand_addr_s[1:0]]    = 1'b1;
                w_data_d[cand_addr_s[1:0]] = cand_data_s;
                cand_issue_s               = 1'b1;
            end else begin
                cand_issue_s = 1'b0;
            end
        end else if (cand_v_s) begin
            w_v_d[cand_addr_s[1:0]]    = 1'b1;
            w_addr_d                   = {cand_addr_s[addr_width_lp-1:2], 2'b00};
            w_data_d[cand_addr_s[1:0]] = cand_data_s;
            cand_issue_s               = 1'b1;
        end else begin
            w_v_d = 4'b0000;
        end

        pop_s  = cand_issue_s & ~empty_s;
        push_s = scalar_acc_s & ~(cand_issue_s & empty_s);

        rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        if (push_s && !pop_s) begin
            count_d = count_q + cnt_w_lp'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - cnt_w_lp'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO storage, pointers and the registered write port.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < buf_els_p; i++) begin
                fifo_addr_q[i] <= {addr_width_lp{1'b0}};
                fifo_data_q[i] <= {width_p{1'b0}};
            end
            fifo_vld_q <= {buf_els_p{1'b0}};
            rd_ptr_q   <= {ptr_w_lp{1'b0}};
            wr_ptr_q   <= {ptr_w_lp{1'b0}};
            count_q    <= {cnt_w_lp{1'b0}};
            w_v_q      <= 4'b0000;
            w_addr_q   <= {addr_width_lp{1'b0}};
            w_data_q   <= {(4*width_p){1'b0}};
        end else begin
            if (pop_s) begin
                fifo_vld_q[rd_ptr_q] <= 1'b0;
            end else begin
                fifo_vld_q[rd_ptr_q] <= fifo_vld_q[rd_ptr_q];
            end
            if (push_s) begin
                fifo_addr_q[wr_ptr_q] <= scalar_addr_i;
                fifo_data_q[wr_ptr_q] <= scalar_data_i;
                fifo_vld_q[wr_ptr_q]  <= 1'b1;
            end else begin
                fifo_addr_q[wr_ptr_q] <= fifo_addr_q[wr_ptr_q];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            w_v_q    <= w_v_d;
            // Address and data only move when something is actually written.
            if (w_v_d != 4'b0000) begin
                w_addr_q <= w_addr_d;
                w_data_q <= w_data_d;
            end else begin
                w_addr_q <= w_addr_q;
                w_data_q <= w_data_q;
            end
        end
    end

    assign w_v_o    = w_v_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;

endmodule

// File: tb/tb_simd_wb_merge.sv
// Bench for simd_wb_merge: directed scenarios plus random traffic checked against
// a per-register ordered scoreboard and a register-file image.
module tb_simd_wb_merge;
    localparam int W  = 33;
    localparam int E  = 32;
    localparam int B  = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              scalar_v = 1'b0;
    logic [AW-1:0]     scalar_addr = '0;
    logic [W-1:0]      scalar_data = '0;
    logic              scalar_ready;
    logic              simd_v = 1'b0;
    logic [AW-1:0]     simd_addr = '0;
    logic [3:0]        simd_mask = '0;
    logic [3:0][W-1:0] simd_data = '0;
    logic              simd_ready;
    logic [3:0]        w_v;
    logic [AW-1:0]     w_addr;
    logic [3:0][W-1:0] w_data;

    simd_wb_merge #(.width_p(W), .els_p(E), .buf_els_p(B)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .scalar_v_i(scalar_v), .scalar_addr_i(scalar_addr), .scalar_data_i(scalar_data),
        .scalar_ready_o(scalar_ready),
        .simd_v_i(simd_v), .simd_addr_i(simd_addr), .simd_mask_i(simd_mask),
        .simd_data_i(simd_data), .simd_ready_o(simd_ready),
        .w_v_o(w_v), .w_addr_o(w_addr), .w_data_o(w_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic [W-1:0] d;
        bit          is_simd;
        int          cyc;
    } ent_t;

    ent_t              sb[$];
    logic [W-1:0]      exp_rf [E];
    logic [W-1:0]      dut_rf [E];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    bit                sr, mr;
    bit                sp, mp;
    logic [AW-1:0]     s_a, m_a;
    logic [W-1:0]      s_d;
    logic [3:0]        m_m;
    logic [3:0][W-1:0] m_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {1'($urandom_range(0, 1)), 32'($urandom)};
    endfunction

    task automatic set_in(input bit sv, input int sa, input logic [W-1:0] sd,
                          input bit mv, input int ma, input logic [3:0] mm,
                          input logic [3:0][W-1:0] md);
        scalar_v = sv; scalar_addr = AW'(sa); scalar_data = sd;
        simd_v = mv; simd_addr = AW'(ma); simd_mask = mm; simd_data = md;
    endtask

    task automatic idle();
        set_in(1'b0, 0, '0, 1'b0, 0, 4'b0000, '0);
    endtask

    task automatic observe();
        int r, idx;
        if (w_v != 4'b0000) check("addr_align", 64'(w_addr[1:0]), 64'd0);
        for (int l = 0; l < 4; l++) begin
            if (w_v[l]) begin
                r = int'(w_addr) + l;
                dut_rf[r] = w_data[l];
                idx = -1;
                foreach (sb[k]) if (idx < 0 && sb[k].r == r) idx = k;
                check("stray_write", 64'(idx >= 0), 64'd1);
                if (idx >= 0) begin
                    check("write_order_data", 64'(w_data[l]), 64'(sb[idx].d));
                    if (sb[idx].is_simd) check("simd_latency", 64'(cyc - sb[idx].cyc), 64'd1);
                    sb.delete(idx);
                end
            end
        end
    endtask

    // Capture readiness, log acceptances in age order, clock once, then check the write port.
    task automatic tick();
        int base;
        #1;
        sr = scalar_ready;
        mr = simd_ready;
        if (scalar_v && sr) begin
            sb.push_back('{int'(scalar_addr), scalar_data, 1'b0, cyc});
            exp_rf[int'(scalar_addr)] = scalar_data;
        end
        if (simd_v && mr) begin
            base = int'(simd_addr) & ~3;
            for (int l = 0; l < 4; l++) begin
                if (simd_mask[l]) begin
                    sb.push_back('{base + l, simd_data[l], 1'b1, cyc});
                    exp_rf[base + l] = simd_data[l];
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic clear_models();
        sb.delete();
        for (int i = 0; i < E; i++) begin
            exp_rf[i] = '0;
            dut_rf[i] = '0;
        end
    endtask

    initial begin
        clear_models();
        #1;
        check("rst_wv", 64'(w_v), 64'd0);
        check("rst_waddr", 64'(w_addr), 64'd0);
        check("rst_wdata0", 64'(w_data[0]), 64'd0);
        check("rst_wdata3", 64'(w_data[3]), 64'd0);
        check("rst_sready", 64'(scalar_ready), 64'd1);
        check("rst_mready", 64'(simd_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Scalar alone
        set_in(1'b1, 5, 33'h1, 1'b0, 0, 4'b0000, '0);
        tick();
        check("t1_sready", 64'(sr), 64'd1);
        check("t1_wv", 64'(w_v), 64'h2);
        check("t1_waddr", 64'(w_addr), 64'd4);
        check("t1_lane1", 64'(w_data[1]), 64'h1);
        idle(); tick();
        check("t1_idle_wv", 64'(w_v), 64'd0);

        // Merge into free lane
        m_d = '{33'h0A3, 33'h0A2, 33'h0A1, 33'h0A0};
        set_in(1'b1, 10, 33'h7, 1'b1, 8, 4'b1011, m_d);
        tick();
        check("t2_mready", 64'(mr), 64'd1);
        check("t2_wv", 64'(w_v), 64'hF);
        check("t2_waddr", 64'(w_addr), 64'd8);
        check("t2_lane2", 64'(w_data[2]), 64'h7);
        check("t2_lane0", 64'(w_data[0]), 64'h0A0);
        idle(); tick();
        check("t2_empty_wv", 64'(w_v), 64'd0);
        check("t2_hold_addr", 64'(w_addr), 64'd8);

        // Lane hazard
        m_d = '{33'h0, 33'h55, 33'h0, 33'h0};
        set_in(1'b1, 10, 33'h3, 1'b1, 8, 4'b0100, m_d);
        tick();
        check("t3_mready0", 64'(mr), 64'd0);
        check("t3_wv1", 64'(w_v), 64'h4);
        check("t3_lane2_s", 64'(w_data[2]), 64'h3);
        set_in(1'b0, 0, '0, 1'b1, 8, 4'b0100, m_d);
        tick();
        check("t3_mready1", 64'(mr), 64'd1);
        check("t3_wv2", 64'(w_v), 64'h4);
        check("t3_lane2_v", 64'(w_data[2]), 64'h55);
        idle(); tick();

        // Different rows
        m_d = '{33'h0, 33'h0, 33'h0, 33'h11};
        set_in(1'b1, 12, 33'h22, 1'b1, 0, 4'b0001, m_d);
        tick();
        check("t4_mready", 64'(mr), 64'd1);
        check("t4_wv_simd", 64'(w_v), 64'h1);
        check("t4_waddr_simd", 64'(w_addr), 64'd0);
        idle(); tick();
        check("t4_wv_sc", 64'(w_v), 64'h1);
        check("t4_waddr_sc", 64'(w_addr), 64'd12);
        check("t4_lane0_sc", 64'(w_data[0]), 64'h22);

        // Starvation
        m_d = '{33'h0, 33'h0, 33'h0, 33'h31};
        set_in(1'b1, 16, 33'h16, 1'b1, 0, 4'b0001, m_d);
        tick();
        m_d[0] = 33'h32;
        set_in(1'b1, 20, 33'h20, 1'b1, 0, 4'b0001, m_d);
        tick();
        check("t5_fill_mready", 64'(mr), 64'd1);
        m_d[0] = 33'h33;
        set_in(1'b1, 24, 33'h24, 1'b1, 0, 4'b0001, m_d);
        tick();
        check("t5_full_mready", 64'(mr), 64'd0);
        check("t5_full_sready", 64'(sr), 64'd0);
        check("t5_head_wv", 64'(w_v), 64'h1);
        check("t5_head_addr", 64'(w_addr), 64'd16);
        tick();
        check("t5_resume_mready", 64'(mr), 64'd1);
        check("t5_resume_addr", 64'(w_addr), 64'd0);
        check("t5_resume_lane0", 64'(w_data[0]), 64'h33);
        idle();
        repeat (4) tick();
        check("t5_drained", 64'(sb.size()), 64'd0);

        // Reset mid-run with two FIFO entries
        set_in(1'b1, 16, 33'h1016, 1'b1, 0, 4'b0001, m_d);
        tick();
        set_in(1'b1, 20, 33'h1020, 1'b1, 0, 4'b0001, m_d);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check("t6_rst_wv", 64'(w_v), 64'd0);
        clear_models();
        @(posedge clk); @(negedge clk);
        check("t6_rst_sready", 64'(scalar_ready), 64'd1);
        check("t6_rst_mready", 64'(simd_ready), 64'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_stale", 64'(w_v), 64'd0);
        end

        // Random traffic concentrated on rows 0..2 to provoke merges and hazards
        sp = 1'b0; mp = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!sp && $urandom_range(0, 1) == 1) begin
                sp = 1'b1; s_a = AW'($urandom_range(0, 11)); s_d = rnd();
            end
            if (!mp && $urandom_range(0, 2) != 0) begin
                mp = 1'b1; m_a = AW'($urandom_range(0, 11)); m_m = 4'($urandom_range(0, 15));
                for (int l = 0; l < 4; l++) m_d[l] = rnd();
            end
            set_in(sp, int'(s_a), s_d, mp, int'(m_a), m_m, m_d);
            tick();
            if (sp && sr) sp = 1'b0;
            if (mp && mr) mp = 1'b0;
        end
        idle();
        repeat (8) tick();
        check("rand_drained", 64'(sb.size()), 64'd0);
        for (int i = 0; i < E; i++) check($sformatf("rf_r%0d", i), 64'(dut_rf[i]), 64'(exp_rf[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
